// File: rtl/serial_deframer.sv
// serial_deframer: start/stop serial line receiver with one-deep output holding register
// Ports: clock, reset (sync, active-high); Data_in serial line (idles high);
//        data_ready/data_valid output handshake; ovr_clr clears sticky overrun;
//        data_out last accepted payload; frame_err/parity_err one-cycle error pulses.
// Optional: define SERIAL_DEFRAMER_PARITY_EN for one even-parity bit after the data bits.
module serial_deframer #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Data_in,
    input  logic              data_ready,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
`ifdef SERIAL_DEFRAMER_PARITY_EN
        S_PAR,
`endif
        S_STOP
    } state_t;

    state_t            r_state, w_next;
    logic              r_prev;
    logic [4:0]        r_cnt;
    logic [DATA_W-1:0] r_sh;
    logic              w_good, w_ferr, w_last;

    assign w_last = r_cnt == 5'(DATA_W - 1);
    assign w_good = (r_state == S_STOP) && Data_in;
    assign w_ferr = (r_state == S_STOP) && !Data_in;

`ifdef SERIAL_DEFRAMER_PARITY_EN
    logic w_perr;
    assign w_perr = ^{r_sh, Data_in};
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = (r_prev && !Data_in) ? S_DATA : S_IDLE;
`ifdef SERIAL_DEFRAMER_PARITY_EN
            S_DATA: w_next = w_last ? S_PAR : S_DATA;
            S_PAR:  w_next = w_perr ? S_IDLE : S_STOP;
`else
            S_DATA: w_next = w_last ? S_STOP : S_DATA;
`endif
            S_STOP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prev     <= 1'b1;
            r_cnt      <= '0;
            r_sh       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_prev    <= Data_in;
            r_cnt     <= (r_state == S_DATA) ? r_cnt + 5'd1 : '0;
            frame_err <= w_ferr;
            if (r_state == S_DATA)
                r_sh <= {Data_in, r_sh[DATA_W-1:1]};
            // a completing frame only loads if the holding register is free or being drained
            if (w_good && (!data_valid || data_ready)) begin
                data_out   <= r_sh;
                data_valid <= 1'b1;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
            // setting overrun outranks a simultaneous clear
            if (w_good && data_valid && !data_ready)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

`ifdef SERIAL_DEFRAMER_PARITY_EN
    always_ff @(posedge clock) begin
        if (reset)
            parity_err <= 1'b0;
        else
            parity_err <= (r_state == S_PAR) && w_perr;
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_deframer.sv
// tb_serial_deframer: directed and random frames checked against a frame-level reference model
module tb_serial_deframer;
    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset, Data_in, data_ready, ovr_clr;
    logic [W-1:0] data_out;
    logic         data_valid, frame_err, parity_err, overrun;

    int           n_chk = 0, n_fail = 0;
    logic [W-1:0] m_data;
    logic         m_valid, m_ovr, m_ferr, m_perr;

    always #5 clock = ~clock;

    serial_deframer #(.DATA_W(W)) dut (
        .clock(clock), .reset(reset), .Data_in(Data_in), .data_ready(data_ready),
        .ovr_clr(ovr_clr), .data_out(data_out), .data_valid(data_valid),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_valid", 32'(data_valid), 32'(m_valid));
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("parity_err", 32'(parity_err), 32'(m_perr));
    endtask

    // kind: 0 no completion, 1 good frame ends, 2 bad stop bit, 3 bad parity
    task automatic step(input logic din, input logic rdy, input logic clr, input int kind,
                        input logic [W-1:0] pay);
        @(negedge clock);
        Data_in = din; data_ready = rdy; ovr_clr = clr;
        @(posedge clock);
        m_ferr = kind == 2;
        m_perr = kind == 3;
        if (kind == 1 && m_valid && !rdy) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (kind == 1 && (!m_valid || rdy)) begin
            m_data = pay; m_valid = 1'b1;
        end else if (rdy) m_valid = 1'b0;
        #1 check_all();
    endtask

    task automatic idle(input int n, input logic rdy, input logic clr);
        repeat (n) step(1'b1, rdy, clr, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; Data_in = 1'b1; data_ready = 1'b0; ovr_clr = 1'b0;
        @(posedge clock);
        m_data = '0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
        #1 check_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] b, input logic stop, input logic par,
                        input logic rdy_mid, input logic rdy_stop);
        step(1'b0, rdy_mid, 1'b0, 0, b);
        for (int i = 0; i < W; i++) step(b[i], rdy_mid, 1'b0, 0, b);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        if (^{b, par}) begin
            step(par, rdy_stop, 1'b0, 3, b);
            step(1'b1, rdy_mid, 1'b0, 0, b);
            return;
        end
        step(par, rdy_mid, 1'b0, 0, b);
`endif
        step(stop, rdy_stop, 1'b0, stop ? 1 : 2, b);
    endtask

    initial begin
        logic [W-1:0] b;
        logic         stop, par;
        reset = 1'b1; Data_in = 1'b1; data_ready = 1'b0; ovr_clr = 1'b0;
        do_reset();
        do_reset();
        idle(2, 1'b1, 1'b0);
        send(8'hA5, 1'b1, ^8'hA5, 1'b1, 1'b1);
        idle(3, 1'b1, 1'b0);
        send(8'h3C, 1'b0, ^8'h3C, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b0);
        send(8'h81, 1'b1, ^8'h81, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b0);
        do_reset();
        send(8'h11, 1'b1, ^8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, ^8'h22, 1'b0, 1'b0);
        idle(1, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b1);
        do_reset();
        send(8'h11, 1'b1, ^8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, ^8'h22, 1'b0, 1'b1);
        idle(2, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 1'b1, 1'b0, 0, 8'hFF);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 8'hFF);
        do_reset();
        send(8'h5A, 1'b1, ^8'h5A, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b0);
`ifdef SERIAL_DEFRAMER_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1, 1'b0);
`endif
        for (int k = 0; k < 40; k++) begin
            b    = W'($urandom);
            stop = $urandom_range(0, 5) != 0;
            par  = ($urandom_range(0, 5) != 0) ? ^b : ~^b;
            send(b, stop, par, 1'(($urandom_range(0, 3)) == 0), 1'($urandom));
            idle(stop ? $urandom_range(0, 2) : $urandom_range(1, 2), 1'($urandom), 1'(($urandom_range(0, 3)) == 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
